// File: rtl/mem_access_unit_pkg.sv
// Shared load/store constants and helpers for the memory-access stage.
// XLEN falls back to 32 when the build does not define it.
`ifndef XLEN
`define XLEN 32
`endif

package mem_access_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} mau_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} acc_size_e;

  // Doubleword encodings cannot reach a 32-bit core; fold them onto word.
  function automatic acc_size_e eff_size(input logic [2:0] f3, input int xlen);
    if (f3[1:0] == 2'b11 && xlen == 32) return SZ_W;
    return acc_size_e'(f3[1:0]);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Single-outstanding data-memory request channel plus response channel.
`ifndef XLEN
`define XLEN 32
`endif

interface mem_access_unit_if #(parameter int XLEN = `XLEN);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN/8-1:0] req_wstrb;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Load data extraction: shift the addressed lane down and sign/zero extend.
// Purely combinational; no backpressure.
module load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic [XLEN-1:0]           rdata,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [2:0]                funct3,
  output logic [XLEN-1:0]           data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (funct3)
      F3_LB:  data = XLEN'($signed(shifted[7:0]));
      F3_LBU: data = XLEN'(shifted[7:0]);
      F3_LH:  data = XLEN'($signed(shifted[15:0]));
      F3_LHU: data = XLEN'(shifted[15:0]);
      // Word loads only extend when the register is wider than a word.
      F3_LW:  if (XLEN == 64) data = XLEN'($signed(shifted[31:0]));
      F3_LWU: if (XLEN == 64) data = XLEN'(shifted[31:0]);
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: one access at a time, 4 cycles minimum.
// Holds the pipeline until the response lands; stalls on req_ready/rsp_valid.
`ifndef XLEN
`define XLEN 32
`endif

module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic [2:0]       funct3_in,
  input  logic [XLEN-1:0]  addr_in,
  input  logic [XLEN-1:0]  wdata_in,
  output logic             hold,
  output logic [XLEN-1:0]  load_data,
  output logic             load_done,
  output logic             ld_misaligned,
  output logic             st_misaligned,
  mem_access_unit_if.master mem
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  mau_state_e      state;
  logic [2:0]      f3_q;
  logic [OFFW-1:0] off_q;
  logic            is_load_q;
  logic [XLEN-1:0] ext_data;

  acc_size_e       size;
  logic [OFFW-1:0] off;
  logic            access;
  logic            misaligned;
  logic            access_ok;
  logic [XLEN-1:0] st_data;
  logic [NB-1:0]   st_mask;
  logic [NB-1:0]   st_strb;

  always_comb begin
    size   = eff_size(funct3_in, XLEN);
    off    = addr_in[OFFW-1:0];
    access = valid_in & (mem_read_in | mem_write_in);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = addr_in[0];
      SZ_W:    misaligned = |addr_in[1:0];
      default: misaligned = |addr_in[2:0];
    endcase
    access_ok     = access & ~misaligned;
    ld_misaligned = valid_in & mem_read_in & misaligned;
    st_misaligned = valid_in & mem_write_in & ~mem_read_in & misaligned;
    hold = ((state == ST_IDLE) & access_ok) | (state == ST_REQ) | (state == ST_WAIT);
  end

  // Store data is replicated so every lane the strobe may select carries it.
  always_comb begin
    st_data = wdata_in;
    st_mask = '0;
    case (size)
      SZ_B: begin
        st_data = {NB{wdata_in[7:0]}};
        st_mask = NB'(1);
      end
      SZ_H: begin
        st_data = {(NB/2){wdata_in[15:0]}};
        st_mask = NB'(3);
      end
      SZ_W: begin
        st_data = {(NB/4){wdata_in[31:0]}};
        st_mask = NB'(15);
      end
      default: begin
        st_data = wdata_in;
        st_mask = '1;
      end
    endcase
    st_strb = st_mask << off;
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata  (mem.rsp_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      mem.req_valid <= 1'b0;
      mem.req_we    <= 1'b0;
      mem.req_addr  <= '0;
      mem.req_wdata <= '0;
      mem.req_wstrb <= '0;
      f3_q          <= '0;
      off_q         <= '0;
      is_load_q     <= 1'b0;
      load_data     <= '0;
      load_done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access_ok) begin
            mem.req_valid <= 1'b1;
            mem.req_we    <= ~mem_read_in;
            mem.req_addr  <= {addr_in[XLEN-1:OFFW], {OFFW{1'b0}}};
            mem.req_wdata <= mem_read_in ? '0 : st_data;
            mem.req_wstrb <= mem_read_in ? '0 : st_strb;
            f3_q          <= funct3_in;
            off_q         <= off;
            is_load_q     <= mem_read_in;
            state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem.req_ready) begin
            mem.req_valid <= 1'b0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem.rsp_valid) begin
            if (is_load_q) load_data <= ext_data;
            load_done <= is_load_q;
            state     <= ST_DONE;
          end
        end
        default: begin
          // Pipeline advances this cycle, so inputs are not examined here.
          load_done <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit at XLEN=32 and XLEN=64 with a reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        v32, v64, rd, wr;
  logic [2:0]  f3;
  logic [63:0] addr, wdata, rdata;
  logic        rdy, rsp;

  logic        h32, ld32, lm32, sm32;
  logic [31:0] ldat32;
  logic        h64, ld64, lm64, sm64;
  logic [63:0] ldat64;

  int total = 0;
  int bad   = 0;

  mem_access_unit_if #(.XLEN(32)) if32 ();
  mem_access_unit_if #(.XLEN(64)) if64 ();

  assign if32.req_ready = rdy;
  assign if32.rsp_valid = rsp;
  assign if32.rsp_rdata = rdata[31:0];
  assign if64.req_ready = rdy;
  assign if64.rsp_valid = rsp;
  assign if64.rsp_rdata = rdata;

  mem_access_unit #(.XLEN(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .valid_in(v32), .mem_read_in(rd), .mem_write_in(wr),
    .funct3_in(f3), .addr_in(addr[31:0]), .wdata_in(wdata[31:0]), .hold(h32),
    .load_data(ldat32), .load_done(ld32), .ld_misaligned(lm32), .st_misaligned(sm32),
    .mem(if32)
  );

  mem_access_unit #(.XLEN(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .valid_in(v64), .mem_read_in(rd), .mem_write_in(wr),
    .funct3_in(f3), .addr_in(addr), .wdata_in(wdata), .hold(h64),
    .load_data(ldat64), .load_done(ld64), .ld_misaligned(lm64), .st_misaligned(sm64),
    .mem(if64)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sz_bytes(input int xl, input logic [2:0] f);
    case (f[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return (xl == 64) ? 8 : 4;
    endcase
  endfunction

  function automatic int m_off(input int xl, input logic [63:0] a);
    return int'(a[2:0]) % (xl / 8);
  endfunction

  function automatic bit m_mis(input int xl, input logic [2:0] f, input logic [63:0] a);
    return (int'(a[2:0]) % sz_bytes(xl, f)) != 0;
  endfunction

  function automatic logic [63:0] m_addr(input int xl, input logic [63:0] a);
    return a - 64'(m_off(xl, a));
  endfunction

  function automatic logic [7:0] m_strb(input int xl, input logic [2:0] f, input logic [63:0] a);
    logic [7:0] s;
    s = 8'((16'd1 << sz_bytes(xl, f)) - 16'd1);
    return s << m_off(xl, a);
  endfunction

  function automatic logic [63:0] m_wdata(input int xl, input logic [2:0] f, input logic [63:0] w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < xl / 8; i++) r[8*i +: 8] = w[8*(i % sz_bytes(xl, f)) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(input int xl, input logic [2:0] f,
                                         input logic [63:0] rdv, input logic [63:0] a);
    logic [63:0] v, msk;
    int sz;
    sz = sz_bytes(xl, f);
    v  = (xl == 32) ? (rdv & 64'hFFFF_FFFF) : rdv;
    v  = v >> (8 * m_off(xl, a));
    if (sz < xl / 8) begin
      msk = (64'd1 << (8 * sz)) - 64'd1;
      v   = v & msk;
      if (!f[2] && v[8*sz-1]) v = v | ~msk;
    end
    if (xl == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  bit          mon_en = 0;
  bit          sel64;
  int          exp_xl;
  logic [2:0]  exp_f3;
  logic [63:0] exp_a, exp_w, exp_r;
  bit          exp_ld;
  int          hold_cnt, done_cnt;
  bit          rv_seen;
  logic [63:0] last_addr, last_wdata, last_strb, last_load;
  logic        o_hold, o_rv, o_we, o_done;
  logic [63:0] o_addr, o_wdata, o_strb, o_ldat;

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      check("ldmis32", lm32, v32 & rd & m_mis(32, f3, addr));
      check("stmis32", sm32, v32 & wr & ~rd & m_mis(32, f3, addr));
      check("ldmis64", lm64, v64 & rd & m_mis(64, f3, addr));
      check("stmis64", sm64, v64 & wr & ~rd & m_mis(64, f3, addr));
      o_hold  = sel64 ? h64 : h32;
      o_rv    = sel64 ? if64.req_valid : if32.req_valid;
      o_we    = sel64 ? if64.req_we : if32.req_we;
      o_addr  = sel64 ? if64.req_addr : {32'b0, if32.req_addr};
      o_wdata = sel64 ? if64.req_wdata : {32'b0, if32.req_wdata};
      o_strb  = sel64 ? {56'b0, if64.req_wstrb} : {60'b0, if32.req_wstrb};
      o_done  = sel64 ? ld64 : ld32;
      o_ldat  = sel64 ? ldat64 : {32'b0, ldat32};
      if (o_rv) begin
        rv_seen = 1;
        check("req_we", o_we, !exp_ld);
        check("req_addr", o_addr, m_addr(exp_xl, exp_a));
        check("req_wstrb", o_strb, exp_ld ? 64'd0 : 64'(m_strb(exp_xl, exp_f3, exp_a)));
        if (!exp_ld) check("req_wdata", o_wdata, m_wdata(exp_xl, exp_f3, exp_w));
        last_addr  = o_addr;
        last_wdata = o_wdata;
        last_strb  = o_strb;
      end
      if (o_done) begin
        done_cnt++;
        last_load = o_ldat;
        check("load_data", o_ldat, m_load(exp_xl, exp_f3, exp_r, exp_a));
      end
      if (o_hold) hold_cnt++;
    end
  end

  // ---------------- directed transactions ----------------
  task automatic run(input bit s64, input bit is_ld, input logic [2:0] f, input logic [63:0] a,
                     input logic [63:0] w, input logic [63:0] r, input int rdy_low,
                     input int rsp_dly, input int exp_hold, input logic [63:0] lit_addr,
                     input logic [63:0] lit_wdata, input logic [63:0] lit_strb,
                     input logic [63:0] lit_load);
    int c, wcnt;
    bit acc, got, fin, in_wait;
    sel64 = s64; exp_xl = s64 ? 64 : 32; exp_f3 = f; exp_a = a; exp_w = w; exp_r = r;
    exp_ld = is_ld;
    hold_cnt = 0; done_cnt = 0;
    last_addr = '1; last_wdata = '1; last_strb = '1; last_load = '1;
    rd = is_ld; wr = !is_ld; f3 = f; addr = a; wdata = w; rdata = r;
    if (s64) v64 = 1'b1; else v32 = 1'b1;
    rdy = (rdy_low <= 0); rsp = 1'b0;
    c = 0; wcnt = 0; fin = 0; in_wait = 0;
    while (!fin && c < 60) begin
      @(negedge clk);
      acc = (s64 ? if64.req_valid : if32.req_valid) & rdy;
      got = rsp;
      @(posedge clk); #1;
      c++;
      rdy = (c >= rdy_low);
      if (got) begin
        rsp = 1'b0; v32 = 1'b0; v64 = 1'b0; fin = 1; in_wait = 0;
      end else if (acc) begin
        in_wait = 1; wcnt = 0; rsp = (rsp_dly == 0);
      end else if (in_wait) begin
        wcnt++; rsp = (wcnt >= rsp_dly);
      end
    end
    v32 = 1'b0; v64 = 1'b0; rsp = 1'b0;
    if (!fin) check("txn_timeout", 1, 0);
    @(posedge clk); #1;
    check("hold_cycles", hold_cnt, exp_hold);
    check("done_pulses", done_cnt, is_ld);
    check("lit_addr", last_addr, lit_addr);
    check("lit_strb", last_strb, lit_strb);
    if (!is_ld) check("lit_wdata", last_wdata, lit_wdata);
    if (is_ld) check("lit_load", last_load, lit_load);
  endtask

  task automatic mis_test(input bit s64, input bit is_ld, input logic [2:0] f,
                          input logic [63:0] a);
    sel64 = s64; hold_cnt = 0; rv_seen = 0;
    rd = is_ld; wr = !is_ld; f3 = f; addr = a; wdata = 64'h1234; rsp = 1'b0; rdy = 1'b1;
    if (s64) v64 = 1'b1; else v32 = 1'b1;
    @(negedge clk);
    check("mis_flag", s64 ? (is_ld ? lm64 : sm64) : (is_ld ? lm32 : sm32), 1);
    check("mis_hold", s64 ? h64 : h32, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    v32 = 1'b0; v64 = 1'b0;
    @(negedge clk);
    check("mis_reqv", rv_seen, 0);
    check("mis_holdcnt", hold_cnt, 0);
  endtask

  task automatic check_zero32(input string nm);
    check({nm, "_hold"}, h32, 0);
    check({nm, "_done"}, ld32, 0);
    check({nm, "_ldat"}, ldat32, 0);
    check({nm, "_rv"}, if32.req_valid, 0);
    check({nm, "_req"}, {if32.req_we, if32.req_addr, if32.req_wdata, if32.req_wstrb}, 0);
    check({nm, "_mis"}, {lm32, sm32}, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    v32 = 0; v64 = 0; rd = 0; wr = 0; f3 = 0; addr = 0; wdata = 0; rdata = 0;
    rdy = 0; rsp = 0; sel64 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero32("rst32");
    check("rst64", {h64, ld64, ldat64, if64.req_valid, if64.req_addr, if64.req_wstrb, lm64, sm64}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1;

    //   s64 ld f3      addr       wdata                  rdata                  rl rs hold lit_addr  lit_wdata              strb   load
    run(0, 1, 3'b000, 64'h1003, 64'h0,                 64'h80FF_FFFF,          0, 0, 3, 64'h1000, 64'h0,                 64'h0,  64'hFFFF_FF80);
    run(0, 0, 3'b001, 64'h2002, 64'h0000_BEEF,         64'h0,                  0, 0, 3, 64'h2000, 64'hBEEF_BEEF,         64'hC,  64'h0);
    run(0, 1, 3'b101, 64'h2006, 64'h0,                 64'h8001_1234,          2, 1, 5, 64'h2004, 64'h0,                 64'h0,  64'h0000_8001);
    run(0, 1, 3'b010, 64'h0100, 64'h0,                 64'hDEAD_BEEF,          3, 2, 7, 64'h0100, 64'h0,                 64'h0,  64'hDEAD_BEEF);
    run(0, 0, 3'b000, 64'h0005, 64'h01A5,              64'h0,                  0, 0, 3, 64'h0004, 64'hA5A5_A5A5,         64'h2,  64'h0);
    run(1, 1, 3'b110, 64'h4004, 64'h0,                 64'h8765_4321_0000_0000, 0, 0, 3, 64'h4000, 64'h0,                64'h0,  64'h0000_0000_8765_4321);
    run(1, 1, 3'b010, 64'h4004, 64'h0,                 64'h8765_4321_0000_0000, 0, 0, 3, 64'h4000, 64'h0,                64'h0,  64'hFFFF_FFFF_8765_4321);
    run(1, 0, 3'b011, 64'h0008, 64'h1122_3344_5566_7788, 64'h0,                0, 0, 3, 64'h0008, 64'h1122_3344_5566_7788, 64'hFF, 64'h0);
    run(1, 0, 3'b010, 64'h000C, 64'h0000_CAFE,         64'h0,                  1, 3, 6, 64'h0008, 64'h0000_CAFE_0000_CAFE, 64'hF0, 64'h0);
    run(1, 1, 3'b000, 64'h0007, 64'h0,                 64'h7F00_0000_0000_0000, 0, 0, 3, 64'h0000, 64'h0,                64'h0,  64'h7F);

    mis_test(0, 1, 3'b010, 64'h3001);
    mis_test(0, 0, 3'b001, 64'h2001);
    mis_test(1, 1, 3'b011, 64'h4004);

    // reset while the 32-bit unit waits for its response
    sel64 = 0; exp_xl = 32; exp_f3 = 3'b010; exp_a = 64'h10; exp_w = 0; exp_r = 64'h1234_5678;
    exp_ld = 1; done_cnt = 0;
    rd = 1; wr = 0; f3 = 3'b010; addr = 64'h10; rdata = 64'h1234_5678; rdy = 1; rsp = 0; v32 = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("wait_hold", h32, 1);
    check("wait_rv", if32.req_valid, 0);
    #1;
    reset_n = 1'b0; v32 = 1'b0;
    #1;
    check_zero32("rstwait");
    @(posedge clk); #1;
    reset_n = 1'b1; rsp = 1'b1;
    @(posedge clk); #1;
    rsp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("late_done", ld32, 0);
      check("late_hold", h32, 0);
      check("late_rv", if32.req_valid, 0);
    end
    check("late_done_cnt", done_cnt, 0);

    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
